// File: rtl/numlock_param_sm.sv
// Two-button (U = 1, Z = 0) number lock with a parametrised code, a timed open window and
// a failure lockout. Define NUMLOCK_CODE_PROG_EN to add run-time code programming.
module numlock_param_sm #(
    parameter int          CODE_LEN       = 4,
    parameter logic [15:0] CODE           = 16'b1011,
    parameter int          OPEN_CYCLES    = 16,
    parameter int          MAX_FAILS      = 3,
    parameter int          LOCKOUT_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              U,
    input  logic                              Z,
`ifdef NUMLOCK_CODE_PROG_EN
    input  logic                              prog_en,
    input  logic [CODE_LEN-1:0]               prog_code,
`endif
    output logic                              Unlock,
    output logic                              Lockout,
    output logic [2:0]                        q_state,
    output logic [$clog2(CODE_LEN)-1:0]       digit_idx,
    output logic [$clog2(MAX_FAILS+1)-1:0]    fail_cnt
);

    localparam int DIDX_W = $clog2(CODE_LEN);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int TMAX   = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W  = $clog2(TMAX);

    localparam logic [CODE_LEN-1:0] CODE_INIT = CODE[CODE_LEN-1:0];
    localparam logic [DIDX_W-1:0]   LAST_IDX  = DIDX_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0]   LAST_FAIL = FAIL_W'(MAX_FAILS - 1);
    localparam logic [TMR_W-1:0]    OPEN_END  = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0]    LOCK_END  = TMR_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GET     = 3'd1,
        S_GOT     = 3'd2,
        S_OPENING = 3'd3,
        S_BAD     = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    state_t              state_reg, state_next;
    logic [DIDX_W-1:0]   idx_reg, idx_next;
    logic [FAIL_W-1:0]   fail_reg, fail_next;
    logic [TMR_W-1:0]    timer_reg, timer_next;
    logic                unlock_reg, lockout_reg;
    logic [CODE_LEN-1:0] code_val;

    logic press_u;
    logic press_z;
    logic press_both;
    logic released;
    logic expected;
    logic digit_ok;

    // Code source: a programmable register when enabled, otherwise the constant.
`ifdef NUMLOCK_CODE_PROG_EN
    logic [CODE_LEN-1:0] code_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_reg <= CODE_INIT;
        end else if (prog_en && (state_reg == S_OPENING)) begin
            code_reg <= prog_code;
        end
    end

    assign code_val = code_reg;
`else
    assign code_val = CODE_INIT;
`endif

    assign press_u    = U & ~Z;
    assign press_z    = Z & ~U;
    assign press_both = U & Z;
    assign released   = ~U & ~Z;
    // First entered digit lives in the MSB of the code.
    assign expected   = code_val[LAST_IDX - idx_reg];
    assign digit_ok   = (press_u & expected) | (press_z & ~expected);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        fail_next  = fail_reg;
        timer_next = timer_reg;

        case (state_reg)
            S_IDLE, S_GOT: begin
                if (press_both) begin
                    state_next = S_BAD;
                end else if (press_u || press_z) begin
                    state_next = digit_ok ? S_GET : S_BAD;
                end
            end

            S_GET: begin
                if (released) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = S_OPENING;
                        idx_next   = '0;
                        fail_next  = '0;
                    end else begin
                        state_next = S_GOT;
                        idx_next   = idx_reg + DIDX_W'(1);
                    end
                end
            end

            S_OPENING: begin
                if (timer_reg == OPEN_END) begin
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end

            S_BAD: begin
                if (released) begin
                    idx_next = '0;
                    if (fail_reg == LAST_FAIL) begin
                        state_next = S_LOCKOUT;
                        fail_next  = '0;
                    end else begin
                        state_next = S_IDLE;
                        fail_next  = fail_reg + FAIL_W'(1);
                    end
                end
            end

            S_LOCKOUT: begin
                // Exit is unconditional; a held button is decoded afresh from IDLE.
                if (timer_reg == LOCK_END) begin
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end

            default: begin
                state_next = S_IDLE;
                idx_next   = '0;
            end
        endcase

        // Every state entry starts its dwell timer from zero.
        if (state_next != state_reg) begin
            timer_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            idx_reg     <= '0;
            fail_reg    <= '0;
            timer_reg   <= '0;
            unlock_reg  <= 1'b0;
            lockout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            fail_reg    <= fail_next;
            timer_reg   <= timer_next;
            unlock_reg  <= (state_next == S_OPENING);
            lockout_reg <= (state_next == S_LOCKOUT);
        end
    end

    assign Unlock    = unlock_reg;
    assign Lockout   = lockout_reg;
    assign q_state   = state_reg;
    assign digit_idx = idx_reg;
    assign fail_cnt  = fail_reg;

endmodule
